mm_to_axi_lite: RTL and testbench

AXI4-Lite master bridge. It turns the team's simple memory-mapped request/ready port into single-beat AXI4-Lite write and read transactions. The local side is the same wr_*/rd_* handshake that the slave-side bridge produces, so an internal engine can drive an external AXI-Lite register space. The write and read paths are independent and may be in flight concurrently.

---
 rtl/mm_to_axi_lite_if.sv | 59 +++++
 rtl/mm_to_axi_lite.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_mm_to_axi_lite.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_to_axi_lite_if.sv
// ---------------------------------------------------------------------------
// mm_to_axi_lite_if
//   AXI4-Lite bus bundle between the mm_to_axi_lite bridge (master modport)
//   and an AXI4-Lite register space (slave modport).
//
//   Parameters : ADDR_BITS - address width
//                DATA_BITS - data width (32 or 64); strobe width is DATA_BITS/8
//   Channels   : AW (awaddr/awprot/awvalid/awready)
//                W  (wdata/wstrb/wvalid/wready)
//                B  (bresp/bvalid/bready)
//                AR (araddr/arprot/arvalid/arready)
//                R  (rdata/rresp/rvalid/rready)
// ---------------------------------------------------------------------------
interface mm_to_axi_lite_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);
  localparam int DATA_BYTES = DATA_BITS / 8;

  logic [ADDR_BITS-1:0]  awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_BITS-1:0]  wdata;
  logic [DATA_BYTES-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_BITS-1:0]  araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [DATA_BITS-1:0]  rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );
endinterface

// File: rtl/mm_to_axi_lite.sv
// ---------------------------------------------------------------------------
// mm_to_axi_lite
//   AXI4-Lite master bridge. Converts the local wr_*/rd_* request/ready
//   handshake into single-beat AXI4-Lite write and read transactions. The
//   write and read paths are fully independent; each holds at most one
//   transaction in flight.
//
//   Ports:
//     m_axi_aclk, m_axi_aresetn   clock, async active-low reset
//     wr_addr/wr_din/wr_be/wr_en  local write request (held until wr_ready)
//     wr_ready, wr_resp           one-cycle completion pulse + BRESP
//     rd_addr/rd_en               local read request (held until rd_ready)
//     rd_dout, rd_ready, rd_resp  read data, completion pulse, RRESP
//     m_axi                       AXI4-Lite master bundle (mm_to_axi_lite_if)
//
//   Build option:
//     MM_TO_AXI_LITE_TIMEOUT_EN   adds a per-path response watchdog of
//                                 TIMEOUT_CYCLES. On expiry the path reports
//                                 resp=2'b10, then drains the late response
//                                 before accepting a new request.
// ---------------------------------------------------------------------------
module mm_to_axi_lite #(
  parameter int ADDR_BITS      = 32,
  parameter int DATA_BITS      = 32,
  parameter int DATA_BYTES     = DATA_BITS / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,

  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_BITS-1:0]  wr_din,
  input  logic [DATA_BYTES-1:0] wr_be,
  input  logic                  wr_en,
  output logic                  wr_ready,
  output logic [1:0]            wr_resp,

  input  logic [ADDR_BITS-1:0]  rd_addr,
  input  logic                  rd_en,
  output logic [DATA_BITS-1:0]  rd_dout,
  output logic                  rd_ready,
  output logic [1:0]            rd_resp,

  mm_to_axi_lite_if.master      m_axi
);

  // Elaboration-time parameter sanity.
  if (DATA_BITS != 32 && DATA_BITS != 64) begin : g_chk_data_bits
    $error("mm_to_axi_lite: DATA_BITS must be 32 or 64");
  end
  if (DATA_BYTES != DATA_BITS / 8) begin : g_chk_data_bytes
    $error("mm_to_axi_lite: DATA_BYTES must equal DATA_BITS/8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
    $error("mm_to_axi_lite: TIMEOUT_CYCLES must be at least 2");
  end

`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
  typedef enum logic [2:0] {W_IDLE, W_REQ, W_RESP, W_DONE, W_DRAIN} w_state_t;
  typedef enum logic [2:0] {R_IDLE, R_ADDR, R_DATA, R_DONE, R_DRAIN} r_state_t;
  // Wide enough to hold TIMEOUT_CYCLES itself so the count never wraps.
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
`else
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_DONE} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_t;
`endif

  // ------------------------------------------------------------------ write
  w_state_t              w_state, w_next;
  logic                  aw_pend, w_pend;
  logic [ADDR_BITS-1:0]  awaddr_q;
  logic [DATA_BITS-1:0]  wdata_q;
  logic [DATA_BYTES-1:0] wstrb_q;
  logic [1:0]            wr_resp_q;
  logic                  bready_c;
  logic                  aw_hs, w_hs;

  assign aw_hs = aw_pend & m_axi.awready;
  assign w_hs  = w_pend  & m_axi.wready;

`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
  logic [TO_W-1:0] w_cnt;
  logic            w_to, w_timeout, w_expire;
  assign w_expire = (w_cnt >= TO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) w_state <= W_IDLE;
    else                w_state <= w_next;
  end

  always_comb begin
    w_next   = w_state;
    bready_c = 1'b0;
`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    case (w_state)
      W_IDLE: if (wr_en) w_next = W_REQ;
      W_REQ: begin
        // AW and W retire independently; move on once both have.
        if ((!aw_pend || aw_hs) && (!w_pend || w_hs)) w_next = W_RESP;
`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
        if (w_expire) begin
          w_next    = W_DONE;
          w_timeout = 1'b1;
        end
`endif
      end
      W_RESP: begin
        bready_c = 1'b1;
        if (m_axi.bvalid) w_next = W_DONE;
`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
        else if (w_expire) begin
          w_next    = W_DONE;
          w_timeout = 1'b1;
        end
`endif
      end
`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
      W_DONE: w_next = w_to ? W_DRAIN : W_IDLE;
      W_DRAIN: begin
        // Swallow the late response once AW/W have finally retired.
        bready_c = 1'b1;
        if (!aw_pend && !w_pend && m_axi.bvalid) w_next = W_IDLE;
      end
`else
      W_DONE: w_next = W_IDLE;
`endif
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wr_resp_q <= 2'b00;
`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
      w_cnt     <= '0;
      w_to      <= 1'b0;
`endif
    end else begin
      if (w_state == W_IDLE && wr_en) begin
        awaddr_q <= wr_addr;
        wdata_q  <= wr_din;
        wstrb_q  <= wr_be;
        aw_pend  <= 1'b1;
        w_pend   <= 1'b1;
      end else begin
        if (aw_hs) aw_pend <= 1'b0;
        if (w_hs)  w_pend  <= 1'b0;
      end
      if (w_state == W_RESP && m_axi.bvalid) wr_resp_q <= m_axi.bresp;
`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
      if (w_timeout) begin
        wr_resp_q <= 2'b10;
        w_to      <= 1'b1;
      end
      if (w_state == W_IDLE) begin
        w_cnt <= '0;
        w_to  <= 1'b0;
      end else if (w_state == W_REQ || w_state == W_RESP) begin
        w_cnt <= w_cnt + 1'b1;
      end
`endif
    end
  end

  assign wr_ready      = (w_state == W_DONE);
  assign wr_resp       = wr_resp_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = aw_pend;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = w_pend;
  assign m_axi.bready  = bready_c;

  // ------------------------------------------------------------------- read
  r_state_t             r_state, r_next;
  logic                 ar_pend;
  logic [ADDR_BITS-1:0] araddr_q;
  logic [DATA_BITS-1:0] rd_dout_q;
  logic [1:0]           rd_resp_q;
  logic                 rready_c;
  logic                 ar_hs;

  assign ar_hs = ar_pend & m_axi.arready;

`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
  logic [TO_W-1:0] r_cnt;
  logic            r_to, r_timeout, r_expire;
  assign r_expire = (r_cnt >= TO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) r_state <= R_IDLE;
    else                r_state <= r_next;
  end

  always_comb begin
    r_next   = r_state;
    rready_c = 1'b0;
`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
    r_timeout = 1'b0;
`endif
    case (r_state)
      R_IDLE: if (rd_en) r_next = R_ADDR;
      R_ADDR: begin
        if (ar_hs) r_next = R_DATA;
`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
        if (r_expire) begin
          r_next    = R_DONE;
          r_timeout = 1'b1;
        end
`endif
      end
      R_DATA: begin
        rready_c = 1'b1;
        if (m_axi.rvalid) r_next = R_DONE;
`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
        else if (r_expire) begin
          r_next    = R_DONE;
          r_timeout = 1'b1;
        end
`endif
      end
`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
      R_DONE: r_next = r_to ? R_DRAIN : R_IDLE;
      R_DRAIN: begin
        rready_c = 1'b1;
        if (!ar_pend && m_axi.rvalid) r_next = R_IDLE;
      end
`else
      R_DONE: r_next = R_IDLE;
`endif
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      ar_pend   <= 1'b0;
      araddr_q  <= '0;
      rd_dout_q <= '0;
      rd_resp_q <= 2'b00;
`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
      r_cnt     <= '0;
      r_to      <= 1'b0;
`endif
    end else begin
      if (r_state == R_IDLE && rd_en) begin
        araddr_q <= rd_addr;
        ar_pend  <= 1'b1;
      end else if (ar_hs) begin
        ar_pend  <= 1'b0;
      end
      if (r_state == R_DATA && m_axi.rvalid) begin
        rd_dout_q <= m_axi.rdata;
        rd_resp_q <= m_axi.rresp;
      end
`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
      // Timeout reports an error but leaves the previous read data alone.
      if (r_timeout) begin
        rd_resp_q <= 2'b10;
        r_to      <= 1'b1;
      end
      if (r_state == R_IDLE) begin
        r_cnt <= '0;
        r_to  <= 1'b0;
      end else if (r_state == R_ADDR || r_state == R_DATA) begin
        r_cnt <= r_cnt + 1'b1;
      end
`endif
    end
  end

  assign rd_ready      = (r_state == R_DONE);
  assign rd_dout       = rd_dout_q;
  assign rd_resp       = rd_resp_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = ar_pend;
  assign m_axi.rready  = rready_c;

endmodule

// File: tb/tb_mm_to_axi_lite.sv
// ---------------------------------------------------------------------------
// tb_mm_to_axi_lite
//   Directed bench for mm_to_axi_lite with a delay-configurable AXI-Lite
//   slave model. Expected AXI payloads and local responses are queued when
//   a request is driven and compared as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_mm_to_axi_lite;
  localparam int AB = 32;
  localparam int DB = 32;
  localparam int BB = DB / 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AB-1:0] wr_addr, rd_addr;
  logic [DB-1:0] wr_din, rd_dout;
  logic [BB-1:0] wr_be;
  logic          wr_en, rd_en, wr_ready, rd_ready;
  logic [1:0]    wr_resp, rd_resp;

  always #5 clk = ~clk;

  mm_to_axi_lite_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) ax ();

  mm_to_axi_lite #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .DATA_BYTES(BB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be), .wr_en(wr_en),
    .wr_ready(wr_ready), .wr_resp(wr_resp),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_dout(rd_dout),
    .rd_ready(rd_ready), .rd_resp(rd_resp),
    .m_axi(ax)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ slave model
  int         aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic       b_en = 1'b1, r_en = 1'b1;
  logic [1:0] b_resp_v = 2'b00, r_resp_v = 2'b00;
  logic [31:0] r_data_v = '0;
  int         aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic       aw_got, w_got, b_pend, r_pend;
  logic       aw_hs, w_hs, ar_hs;

  assign ax.awready = ax.awvalid && (aw_cnt >= aw_dly);
  assign ax.wready  = ax.wvalid  && (w_cnt  >= w_dly);
  assign ax.arready = ax.arvalid && (ar_cnt >= ar_dly);
  assign ax.bvalid  = b_pend && b_en && (b_cnt >= b_dly);
  assign ax.bresp   = b_resp_v;
  assign ax.rvalid  = r_pend && r_en && (r_cnt >= r_dly);
  assign ax.rdata   = r_data_v;
  assign ax.rresp   = r_resp_v;
  assign aw_hs = ax.awvalid && ax.awready;
  assign w_hs  = ax.wvalid  && ax.wready;
  assign ar_hs = ax.arvalid && ax.arready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      if (aw_hs) aw_cnt <= 0; else if (ax.awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs)  w_cnt  <= 0; else if (ax.wvalid)  w_cnt  <= w_cnt + 1;
      if (ar_hs) ar_cnt <= 0; else if (ax.arvalid) ar_cnt <= ar_cnt + 1;
      if (ax.bvalid && ax.bready) begin
        b_pend <= 1'b0;
        b_cnt  <= 0;
      end else if (b_pend) begin
        if (!ax.bvalid) b_cnt <= b_cnt + 1;
      end else if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        b_pend <= 1'b1;
        b_cnt  <= 0;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (ax.rvalid && ax.rready) begin
        r_pend <= 1'b0;
        r_cnt  <= 0;
      end else if (r_pend) begin
        if (!ax.rvalid) r_cnt <= r_cnt + 1;
      end else if (ar_hs) begin
        r_pend <= 1'b1;
        r_cnt  <= 0;
      end
    end
  end

  // ------------------------------------------------------------- scoreboard
  typedef struct { logic [31:0] data; logic [1:0] resp; } rd_exp_t;
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];      // {strb, data}
  logic [31:0] ar_q[$];
  logic [1:0]  wr_exp_q[$];
  rd_exp_t     rd_exp_q[$];
  int          wr_pulses = 0, rd_pulses = 0;

  logic        p_aw, p_w, p_ar;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
    end else begin
      if (aw_hs) begin
        if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
        else check("awaddr", ax.awaddr, aw_q.pop_front());
      end
      if (w_hs) begin
        if (w_q.size() == 0) check("w_unexpected", 1, 0);
        else check("wstrb_wdata", {ax.wstrb, ax.wdata}, w_q.pop_front());
      end
      if (ar_hs) begin
        if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
        else check("araddr", ax.araddr, ar_q.pop_front());
      end
      if (wr_ready) begin
        wr_pulses <= wr_pulses + 1;
        if (wr_exp_q.size() == 0) check("wr_ready_unexpected", 1, 0);
        else check("wr_resp", wr_resp, wr_exp_q.pop_front());
      end
      if (rd_ready) begin
        rd_pulses <= rd_pulses + 1;
        if (rd_exp_q.size() == 0) check("rd_ready_unexpected", 1, 0);
        else check("rd_dout_resp", {rd_resp, rd_dout}, {rd_exp_q[0].resp, rd_exp_q.pop_front().data});
      end
      // A valid that was waiting last cycle must still be up with the same payload.
      if (p_aw) check("aw_hold", {ax.awvalid, ax.awaddr}, {1'b1, p_awaddr});
      if (p_w)  check("w_hold", {ax.wvalid, ax.wstrb, ax.wdata}, {1'b1, p_wstrb, p_wdata});
      if (p_ar) check("ar_hold", {ax.arvalid, ax.araddr}, {1'b1, p_araddr});
      p_aw <= ax.awvalid && !aw_hs; p_awaddr <= ax.awaddr;
      p_w  <= ax.wvalid  && !w_hs;  p_wdata  <= ax.wdata; p_wstrb <= ax.wstrb;
      p_ar <= ax.arvalid && !ar_hs; p_araddr <= ax.araddr;
    end
  end

  // -------------------------------------------------------------- stimulus
  int t_wr, t_rd, aw_first, w_first, ar_first, b_first, aw_hi, w_hi;
  int p0;

  task automatic issue_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic [1:0] resp);
    wr_addr = a; wr_din = d; wr_be = be; wr_en = 1'b1;
    b_resp_v = resp;
    aw_q.push_back(a);
    w_q.push_back({be, d});
    wr_exp_q.push_back(resp);
  endtask

  task automatic issue_rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    rd_exp_t e;
    rd_addr = a; rd_en = 1'b1;
    r_data_v = d; r_resp_v = resp;
    ar_q.push_back(a);
    e.data = d; e.resp = resp;
    rd_exp_q.push_back(e);
  endtask

  // Cycle 1 is the first cycle after the request is sampled.
  task automatic run(input int max);
    t_wr = -1; t_rd = -1; aw_first = -1; w_first = -1; ar_first = -1; b_first = -1;
    aw_hi = 0; w_hi = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #1;
      if (ax.awvalid) begin aw_hi++; if (aw_first < 0) aw_first = i; end
      if (ax.wvalid)  begin w_hi++;  if (w_first < 0)  w_first  = i; end
      if (ax.arvalid && ar_first < 0) ar_first = i;
      if (ax.bready && b_first < 0)   b_first  = i;
      if (wr_en && wr_ready) begin t_wr = i; wr_en = 1'b0; end
      if (rd_en && rd_ready) begin t_rd = i; rd_en = 1'b0; end
      if (!wr_en && !rd_en) break;
    end
    if (wr_en || rd_en) begin
      check("completion_timeout", {wr_en, rd_en}, 2'b00);
      wr_en = 1'b0; rd_en = 1'b0;
    end
  endtask

  initial begin
    wr_addr = '0; wr_din = '0; wr_be = '0; wr_en = 1'b0;
    rd_addr = '0; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", {ax.awvalid, ax.wvalid, ax.bready, ax.arvalid, ax.rready}, 5'b0);
    check("rst_pulses", {wr_ready, rd_ready}, 2'b00);
    check("rst_resp_dout", {wr_resp, rd_resp, rd_dout}, 36'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write, slave always ready.
    issue_wr(32'h10, 32'hA5A5_0001, 4'hF, 2'b00);
    run(20);
    check("t1_aw_first", aw_first, 1);
    check("t1_w_first", w_first, 1);
    check("t1_bready_cycle", b_first, 2);
    check("t1_wr_ready_cycle", t_wr, 3);
    @(posedge clk); #1;

    // awready delayed 3 cycles, wready immediate.
    aw_dly = 3;
    p0 = wr_pulses;
    issue_wr(32'h14, 32'h0BAD_F00D, 4'h5, 2'b01);
    run(30);
    check("t2_awvalid_cycles", aw_hi, 4);
    check("t2_wvalid_cycles", w_hi, 1);
    check("t2_wr_ready_cycle", t_wr, 6);
    repeat (3) @(posedge clk);
    #1;
    check("t2_single_pulse", wr_pulses - p0, 1);
    check("t2_wr_resp_hold", wr_resp, 2'b01);
    aw_dly = 0;

    // Read with 2-cycle rvalid delay and SLVERR.
    r_dly = 2;
    issue_rd(32'h24, 32'hDEAD_BEEF, 2'b10);
    run(30);
    check("t3_ar_first", ar_first, 1);
    check("t3_rd_ready_cycle", t_rd, 5);
    repeat (2) @(posedge clk);
    #1;
    check("t3_rd_hold", {rd_resp, rd_dout}, {2'b10, 32'hDEAD_BEEF});
    r_dly = 0;

    // Concurrent write and read.
    b_dly = 2;
    issue_wr(32'h100, 32'h1234_5678, 4'h3, 2'b00);
    issue_rd(32'h200, 32'hCAFE_F00D, 2'b00);
    run(30);
    check("t4_first_valids", {aw_first, w_first, ar_first}, {32'd1, 32'd1, 32'd1});
    check("t4_rd_ready_cycle", t_rd, 3);
    check("t4_wr_ready_cycle", t_wr, 5);
    b_dly = 0;
    @(posedge clk); #1;

    // Reset while waiting in W_RESP.
    b_en = 1'b0;
    issue_wr(32'h30, 32'h3333_3333, 4'hF, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    check("t5_in_wresp", ax.bready, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valids", {ax.awvalid, ax.wvalid, ax.bready}, 3'b000);
    check("t5_rst_outputs", {wr_ready, rd_dout}, 33'h0);
    wr_en = 1'b0;
    wr_exp_q.delete(); aw_q.delete(); w_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    b_en = 1'b1;
    @(posedge clk); #1;
    issue_wr(32'h34, 32'h4444_4444, 4'hC, 2'b00);
    run(20);
    check("t5_fresh_write", t_wr, 3);
    @(posedge clk); #1;

`ifdef MM_TO_AXI_LITE_TIMEOUT_EN
    // Slave withholds bvalid past the watchdog.
    b_en = 1'b0;
    p0 = wr_pulses;
    issue_wr(32'h40, 32'h5555_AAAA, 4'hF, 2'b10);
    run(100);
    check("t6_timeout_cycle", t_wr, TO + 1);
    repeat (3) @(posedge clk);
    b_en = 1'b1;
    b_resp_v = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    check("t6_no_second_pulse", wr_pulses - p0, 1);
    check("t6_drained", {b_pend, ax.bvalid}, 2'b00);
    issue_wr(32'h44, 32'h6666_0000, 4'hF, 2'b00);
    run(40);
    check("t6_next_write", t_wr, 3);
    @(posedge clk); #1;
`endif

    check("sb_empty", aw_q.size() + w_q.size() + ar_q.size() + wr_exp_q.size() + rd_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
